// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter/receiver pair.
package uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: reloads on restart or at terminal count, flags the
// half-bit and full-bit points measured from the last restart/reload.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 2500
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic half_tick_o,
    output logic full_tick_o
);
    localparam int              CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   RELOAD   = CW'(CLKS_PER_BIT - 1);
    // Value reached after exactly CLKS_PER_BIT/2 cycles of counting down from RELOAD.
    localparam logic [CW-1:0]   HALF_CNT = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        if (restart_i || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_tick_o = (cnt_q == '0);
    assign half_tick_o = (cnt_q == HALF_CNT);

endmodule

// File: rtl/uart_txrx.sv
// 8N1 UART: independent transmit and receive FSMs sharing only clock and reset.
//
// TX state   | meaning
// TX_IDLE    | line high, waiting for flush
// TX_START   | driving start bit (0)
// TX_DATA    | driving data bits LSB first
// TX_STOP    | driving stop bit (1)
//
// RX state     | meaning
// RX_IDLE      | waiting for a synchronised low
// RX_START     | confirming start bit at mid-bit
// RX_DATA      | sampling 8 data bits at mid-bit
// RX_STOP      | sampling stop bit, publishing byte if valid
// RX_WAIT_IDLE | framing error, waiting for line to return high
module uart_txrx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] to_sent,
    input  logic       flush,
    output logic       serial_tx,
    output logic       busy,
    input  logic       serial_rx,
    output logic [7:0] received,
    output logic       ready
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_idx_q, tx_idx_d;
    logic       tx_restart, tx_full_tick, tx_half_tick_unused;

    rx_state_t  rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] rx_idx_q, rx_idx_d;
    logic [7:0] received_q, received_d;
    logic       ready_q, ready_d;
    logic       rx_meta_q, rx_sync_q;
    logic       rx_restart, rx_half_tick, rx_full_tick;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .restart_i  (tx_restart),
        .half_tick_o(tx_half_tick_unused),
        .full_tick_o(tx_full_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .restart_i  (rx_restart),
        .half_tick_o(rx_half_tick),
        .full_tick_o(rx_full_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_idx_q   <= tx_idx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_idx_d   = tx_idx_q;
        case (tx_state_q)
            TX_IDLE: if (flush) begin
                tx_shift_d = to_sent;
                tx_idx_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_full_tick) tx_state_d = TX_DATA;
            TX_DATA: if (tx_full_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_idx_d   = tx_idx_q + 3'd1;
                if (tx_idx_q == LAST_BIT) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_full_tick) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        serial_tx  = IDLE_LEVEL;
        busy       = 1'b1;
        tx_restart = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                busy       = 1'b0;
                tx_restart = 1'b1;
            end
            TX_START: serial_tx = 1'b0;
            TX_DATA:  serial_tx = tx_shift_q[0];
            TX_STOP:  serial_tx = IDLE_LEVEL;
            default:  busy      = 1'b0;
        endcase
    end

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_sync_q <= IDLE_LEVEL;
        end else begin
            rx_meta_q <= serial_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_shift_q <= '0;
            rx_idx_q   <= '0;
            received_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_shift_q <= rx_shift_d;
            rx_idx_q   <= rx_idx_d;
            received_q <= received_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_shift_d = rx_shift_q;
        rx_idx_d   = rx_idx_q;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync_q) begin
                rx_idx_d   = '0;
                rx_state_d = RX_START;
            end
            RX_START: if (rx_half_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA: if (rx_full_tick) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_idx_d   = rx_idx_q + 3'd1;
                if (rx_idx_q == LAST_BIT) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_full_tick) rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rx_sync_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // The timer is re-armed at mid-start so every later full tick lands mid-bit.
    always_comb begin
        received_d = received_q;
        ready_d    = 1'b0;
        rx_restart = 1'b0;
        case (rx_state_q)
            RX_IDLE, RX_WAIT_IDLE: rx_restart = 1'b1;
            RX_START: rx_restart = rx_half_tick;
            RX_STOP: if (rx_full_tick && rx_sync_q) begin
                received_d = rx_shift_q;
                ready_d    = 1'b1;
            end
            default: rx_restart = 1'b0;
        endcase
    end

    assign received = received_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx with a queue scoreboard checking every ready pulse.
module tb_uart_txrx;
    import uart_pkg::*;

    localparam int CPB     = 16;
    localparam int CPB_BIG = 2500;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] to_sent;
    logic       flush;
    logic       serial_tx, busy;
    logic       rx_line, rx_drv, use_loop;
    logic [7:0] received;
    logic       ready;

    logic [7:0] to_sent_b;
    logic       flush_b;
    logic       serial_tx_b, busy_b;
    logic [7:0] received_b;
    logic       ready_b;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_big_q[$];

    always #5 clk = ~clk;

    assign rx_line = use_loop ? serial_tx : rx_drv;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .to_sent  (to_sent),
        .flush    (flush),
        .serial_tx(serial_tx),
        .busy     (busy),
        .serial_rx(rx_line),
        .received (received),
        .ready    (ready)
    );

    uart_txrx #(.CLKS_PER_BIT(CPB_BIG)) dut_big (
        .clk      (clk),
        .rst      (rst),
        .to_sent  (to_sent_b),
        .flush    (flush_b),
        .serial_tx(serial_tx_b),
        .busy     (busy_b),
        .serial_rx(serial_tx_b),
        .received (received_b),
        .ready    (ready_b)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitors: every ready pulse must match the oldest outstanding expected byte.
    always @(posedge clk) begin
        #1;
        if (ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rx_unexpected_ready: received=0x%0h, expected no ready", received);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (received !== e) begin
                    fails++;
                    $display("FAIL rx_byte: received=0x%0h, expected 0x%0h", received, e);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ready_b) begin
            tests++;
            if (exp_big_q.size() == 0) begin
                fails++;
                $display("FAIL rx_big_unexpected_ready: received=0x%0h, expected no ready", received_b);
            end else begin
                logic [7:0] e;
                e = exp_big_q.pop_front();
                if (received_b !== e) begin
                    fails++;
                    $display("FAIL rx_big_byte: received=0x%0h, expected 0x%0h", received_b, e);
                end
            end
        end
    end

    // Flush one byte in loopback, measure busy width and mid-bit serial_tx values.
    task automatic send(input logic [7:0] b, input bit midflush);
        int         n;
        logic [9:0] bits;
        exp_q.push_back(b);
        to_sent = b;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n     = 0;
        bits  = '0;
        while (busy && n < 400) begin
            if (n < 10 * CPB && n % CPB == CPB / 2) bits[n / CPB] = serial_tx;
            if (midflush && n == 50) begin
                to_sent = 8'h3C;
                flush   = 1'b1;
            end
            if (midflush && n == 51) flush = 1'b0;
            n++;
            @(negedge clk);
        end
        check("busy_width", n, 10 * CPB);
        check("tx_bits", int'(bits), int'({1'b1, b, 1'b0}));
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        int         n;
        logic [9:0] bits;
        rst       = 1'b0;
        to_sent   = '0;
        flush     = 1'b0;
        rx_drv    = 1'b1;
        use_loop  = 1'b1;
        to_sent_b = '0;
        flush_b   = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_serial_tx", serial_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_received", received, 0);
        check("rst_ready", ready, 0);
        check("rst_big_serial_tx", serial_tx_b, 1);
        check("rst_big_busy", busy_b, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        send(8'hD5, 1'b0);

        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hA5, 1'b0);
        repeat (4) @(negedge clk);

        send(8'h96, 1'b1);
        repeat (3) @(negedge clk);
        check("flush_not_queued", busy, 0);
        repeat (20) @(negedge clk);

        use_loop = 1'b0;
        rx_drv   = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_rx_idle", int'(dut.rx_state_q), int'(RX_IDLE));
        exp_q.push_back(8'h81);
        drive_frame(8'h81, 1'b1);

        drive_frame(8'h55, 1'b0);
        check("framing_keeps_received", received, 8'h81);
        exp_q.push_back(8'h12);
        drive_frame(8'h12, 1'b1);
        check("after_framing_received", received, 8'h12);

        use_loop = 1'b1;
        repeat (4) @(negedge clk);
        to_sent = 8'hD5;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (70) @(negedge clk);
        check("midframe_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("async_rst_serial_tx", serial_tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_received", received, 0);
        check("async_rst_ready", ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send(8'hD5, 1'b0);
        repeat (10) @(negedge clk);

        exp_big_q.push_back(8'hD5);
        to_sent_b = 8'hD5;
        flush_b   = 1'b1;
        @(negedge clk);
        flush_b = 1'b0;
        n       = 0;
        bits    = '0;
        while (busy_b && n < 30000) begin
            if (n < 10 * CPB_BIG && n % CPB_BIG == CPB_BIG / 2) bits[n / CPB_BIG] = serial_tx_b;
            n++;
            @(negedge clk);
        end
        check("big_busy_width", n, 10 * CPB_BIG);
        check("big_tx_bits", int'(bits), int'({1'b1, 8'hD5, 1'b0}));
        repeat (10) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("big_scoreboard_drained", exp_big_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
Name: uart_txrx

Overview:
- 8N1 UART transmitter and receiver sharing one clock and one reset; both halves are independent.
- The transmitter serialises a parallel byte on a one-cycle `flush` request.
- The receiver deserialises the line, presents the byte, and pulses `ready` for each valid frame.
- Sits between byte-level logic and the board's serial pins; supports a direct `serial_tx` -> `serial_rx` loopback.

Parameters:
- CLKS_PER_BIT, 2500, clock cycles per bit (12 MHz clk / 4800 baud); integer >= 4.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- to_sent  in  8  byte to transmit; sampled only when a flush is accepted.
- flush  in  1  transmit request; one-cycle pulse or level, accepted only when idle.
- serial_tx  out  1  serial line out; idle high.
- busy  out  1  high while a transmit frame is in progress.
- serial_rx  in  1  serial line in; asynchronous to clk, idle high.
- received  out  8  last correctly framed byte.
- ready  out  1  one-cycle pulse when `received` is updated.

Behaviour:
- Reset (async, immediate, any state):
  - `serial_tx`=1, `busy`=0, `received`=0, `ready`=0.
  - Both FSMs return to IDLE; the rx synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame, with no partial output.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `serial_tx`=1, `busy`=0.
    - If `flush`=1 at a rising edge, latch `to_sent` into a shift register, go to START, set `busy`=1 from the next cycle.
  - START: `serial_tx`=0 for CLKS_PER_BIT cycles.
  - DATA: drive shift-register bit i for CLKS_PER_BIT cycles, i=0..7, using a 3-bit bit index.
  - STOP: `serial_tx`=1 for CLKS_PER_BIT cycles, then IDLE with `busy`=0.
  - `busy` is high for exactly 10*CLKS_PER_BIT cycles per frame.
  - `flush` while `busy`=1 is ignored, not queued.
  - `to_sent` changes after acceptance do not affect the frame in flight.
  - `flush` held high continuously causes back-to-back frames with one IDLE cycle between them.
- RX: `serial_rx` passes through a 2-flop synchroniser; all decisions use the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: a synchronised 0 starts the counter and moves to START.
  - START:
    - After CLKS_PER_BIT/2 cycles (integer division), re-sample the line.
    - If 0, go to DATA; if 1, treat it as a glitch and return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles from mid-start, shifting LSB first, 8 samples.
  - STOP:
    - Sample once more CLKS_PER_BIT later.
    - If 1: load the shift register into `received`, pulse `ready` high for exactly one cycle (the cycle after the sample), go to IDLE.
    - If 0 (framing error): `received` unchanged, no `ready`, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is 1, then IDLE.
  - `received` holds its value between frames.
  - Latency: `ready` follows the start-bit falling edge by 2 (sync) + 9.5*CLKS_PER_BIT + 1 cycles, ±1.
- TX and RX share no state; a simultaneous transmit and receive are fully independent.
- Counters are sized $clog2(CLKS_PER_BIT); no wrap beyond CLKS_PER_BIT-1.

Decomposition:
- Package uart_pkg:
  - tx_state_t and rx_state_t enums.
  - DATA_BITS=8 and the IDLE_LEVEL=1'b1 constant.
- Sub-module uart_bit_timer (parameter CLKS_PER_BIT): counter with a restart input and half-bit/full-bit tick outputs; instantiated once in TX and once in RX.
- Top level holds the two FSMs and the rx synchroniser.

Test Plan (CLKS_PER_BIT=16 unless stated):
- Loopback, 0xD5 (213):
  - Flush at cycle 5 -> `busy` high for 160 cycles.
  - `serial_tx` sequence is 0,1,0,1,0,1,0,1,1,1, each bit 16 cycles.
  - `ready` pulses once, with `received`=0xD5.
- Back-to-back: re-flush 1 cycle after `busy` falls, bytes 0x00, 0xFF, 0xA5 -> three `ready` pulses with matching `received`, with no bit slip.
- Flush while busy: second flush with 0x3C mid-frame -> ignored; only the first byte is received; `busy` width is 160.
- RX glitch: `serial_rx` low for 4 cycles, then high -> no `ready`, FSM back in IDLE; a following valid 0x81 frame is received correctly.
- Framing error: drive a frame of 0x55 with the stop bit 0 -> no `ready`, `received` keeps the previous value; after the line returns high, 0x12 is received.
- Async reset mid-frame, TX at data bit 3:
  - Expected immediately: `serial_tx`=1, `busy`=0, `received`=0.
  - A subsequent flush of 0xD5 works normally.
  - At CLKS_PER_BIT=2500, repeat the loopback with 0xD5.
